// File: rtl/red_pitaya_pfd_quadrature_gen_pkg.sv
// Shared definitions for the i/q quadrant interface: Gray code table and
// quadrant-difference decode, used by both the generator and the detector.
package red_pitaya_pfd_quadrature_gen_pkg;

  typedef logic [1:0] quadrant_t;

  // (target - current) mod 4, interpreted as the step to take
  typedef enum logic [1:0] {
    D_HOLD = 2'd0,
    D_FWD  = 2'd1,
    D_SLIP = 2'd2,
    D_REV  = 2'd3
  } step_d_e;

  // Returns {i, q} for a quadrant: 0->00, 1->10, 2->11, 3->01
  function automatic logic [1:0] quad_to_iq(input quadrant_t quad);
    logic [1:0] iq;
    case (quad)
      2'd0:    iq = 2'b00;
      2'd1:    iq = 2'b10;
      2'd2:    iq = 2'b11;
      default: iq = 2'b01;
    endcase
    return iq;
  endfunction

  // Inverse table for the receiving end
  function automatic quadrant_t iq_to_quad(input logic [1:0] iq);
    quadrant_t quad;
    case (iq)
      2'b00:   quad = 2'd0;
      2'b10:   quad = 2'd1;
      2'b11:   quad = 2'd2;
      default: quad = 2'd3;
    endcase
    return quad;
  endfunction

  function automatic step_d_e quad_diff(input quadrant_t target, input quadrant_t current);
    quadrant_t diff;
    diff = target - current;
    return step_d_e'(diff);
  endfunction

endpackage

// File: rtl/red_pitaya_pfd_quadrature_gen_if.sv
// Control and i/q output bundle of the quadrature generator.
// master = controlling host, slave = generator.
interface red_pitaya_pfd_quadrature_gen_if #(
  parameter int PHASE_BITS = 32,
  parameter int CNT_BITS   = 14
);
  logic                        enable_i;
  logic [PHASE_BITS-1:0]       freq_i;
  logic [PHASE_BITS-1:0]       phase_i;
  logic                        phase_load_i;
  logic                        clr_i;
  logic                        i_o;
  logic                        q_o;
  logic [1:0]                  quadrant_o;
  logic signed [CNT_BITS-1:0]  count_o;
  logic                        slip_o;

  modport master (
    output enable_i, freq_i, phase_i, phase_load_i, clr_i,
    input  i_o, q_o, quadrant_o, count_o, slip_o
  );

  modport slave (
    input  enable_i, freq_i, phase_i, phase_load_i, clr_i,
    output i_o, q_o, quadrant_o, count_o, slip_o
  );
endinterface

// File: rtl/red_pitaya_sat_updown_cnt.sv
// Signed up/down counter that sticks at its extremes; synchronous clear has priority.
module red_pitaya_sat_updown_cnt #(
  parameter int CNT_BITS = 14
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clr_i,
  input  logic                       up_i,
  input  logic                       dn_i,
  output logic signed [CNT_BITS-1:0] count_o
);

  localparam logic signed [CNT_BITS-1:0] CNT_MAX = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic signed [CNT_BITS-1:0] CNT_MIN = {1'b1, {(CNT_BITS-1){1'b0}}};

  logic signed [CNT_BITS-1:0] count_reg;
  logic signed [CNT_BITS-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr_i) begin
      count_next = '0;
    end else if (up_i && !dn_i) begin
      if (count_reg != CNT_MAX) count_next = count_reg + 1'b1;
    end else if (dn_i && !up_i) begin
      if (count_reg != CNT_MIN) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) count_reg <= '0;
    else         count_reg <= count_next;
  end

  assign count_o = count_reg;

endmodule

// File: rtl/red_pitaya_pfd_quadrature_gen.sv
// NCO-driven quadrature square-wave source: the output quadrant chases the
// accumulator's top two bits one step per clock, so i/q only ever change one bit.
module red_pitaya_pfd_quadrature_gen
  import red_pitaya_pfd_quadrature_gen_pkg::*;
#(
  parameter int PHASE_BITS = 32,
  parameter int CNT_BITS   = 14
) (
  input logic                            clk_i,
  input logic                            rstn_i,
  red_pitaya_pfd_quadrature_gen_if.slave bus
);

  logic [PHASE_BITS-1:0] acc_reg;
  logic [PHASE_BITS-1:0] acc_next;
  quadrant_t             quad_reg;
  quadrant_t             quad_next;
  logic [1:0]            iq_reg;
  logic                  slip_reg;
  logic                  slip_next;
  quadrant_t             target;
  step_d_e               step_d;
  logic                  step_up;
  logic                  step_dn;
  logic                  slip_set;

  always_comb begin
    acc_next = acc_reg;
    if (bus.phase_load_i)  acc_next = bus.phase_i;
    else if (bus.enable_i) acc_next = acc_reg + bus.freq_i;
  end

  // Target comes from the registered accumulator, giving one cycle of
  // accumulator-to-output latency.
  assign target = acc_reg[PHASE_BITS-1 -: 2];
  assign step_d = quad_diff(target, quad_reg);

  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    slip_set = 1'b0;
    case (step_d)
      D_FWD:  step_up = 1'b1;
      D_REV:  step_dn = 1'b1;
      D_SLIP: begin
        // Half-turn ambiguity: trust the commanded direction
        slip_set = 1'b1;
        step_up  = ~bus.freq_i[PHASE_BITS-1];
        step_dn  =  bus.freq_i[PHASE_BITS-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    quad_next = quad_reg;
    if (step_up)      quad_next = quad_reg + 2'd1;
    else if (step_dn) quad_next = quad_reg - 2'd1;
  end

  assign slip_next = bus.clr_i ? 1'b0 : (slip_reg | slip_set);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_reg  <= '0;
      quad_reg <= '0;
      iq_reg   <= 2'b00;
      slip_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      quad_reg <= quad_next;
      iq_reg   <= quad_to_iq(quad_next);
      slip_reg <= slip_next;
    end
  end

  red_pitaya_sat_updown_cnt #(
    .CNT_BITS (CNT_BITS)
  ) u_step_cnt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (bus.clr_i),
    .up_i    (step_up),
    .dn_i    (step_dn),
    .count_o (bus.count_o)
  );

  assign bus.i_o        = iq_reg[1];
  assign bus.q_o        = iq_reg[0];
  assign bus.quadrant_o = quad_reg;
  assign bus.slip_o     = slip_reg;

endmodule

// File: tb/tb_red_pitaya_pfd_quadrature_gen.sv
// Self-checking bench: randomized and directed stimulus against a cycle-level
// behavioural model of the quadrant follower.
module tb_red_pitaya_pfd_quadrature_gen;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  red_pitaya_pfd_quadrature_gen_if #(.PHASE_BITS(32), .CNT_BITS(14)) bus ();

  red_pitaya_pfd_quadrature_gen #(.PHASE_BITS(32), .CNT_BITS(14)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #4 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [31:0] m_acc;
  int        m_q;
  int        m_cnt;
  bit        m_slip;
  int        iq_tab [4] = '{0, 2, 3, 1};

  task automatic model_reset();
    m_acc  = '0;
    m_q    = 0;
    m_cnt  = 0;
    m_slip = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented before the edge
  task automatic model_clock();
    int t, d, st;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    t  = int'(m_acc[31:30]);
    d  = (t - m_q + 4) % 4;
    st = (d == 1) ? 1 : (d == 3) ? -1 : (d == 2) ? (bus.freq_i[31] ? -1 : 1) : 0;
    m_q = (m_q + st + 4) % 4;
    if (bus.clr_i) begin
      m_cnt  = 0;
      m_slip = 1'b0;
    end else begin
      if (m_cnt + st <= 8191 && m_cnt + st >= -8192) m_cnt = m_cnt + st;
      if (d == 2) m_slip = 1'b1;
    end
    if (bus.phase_load_i)  m_acc = bus.phase_i;
    else if (bus.enable_i) m_acc = m_acc + bus.freq_i;
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [18:0] obs_vec();
    return {bus.i_o, bus.q_o, bus.quadrant_o, bus.count_o, bus.slip_o};
  endfunction

  function automatic logic [18:0] model_vec();
    logic [1:0]  iq;
    logic [1:0]  qd;
    logic [13:0] c;
    iq = iq_tab[m_q][1:0];
    qd = m_q[1:0];
    c  = m_cnt[13:0];
    return {iq, qd, c, m_slip};
  endfunction

  task automatic drive_idle();
    bus.enable_i     = 1'b0;
    bus.freq_i       = '0;
    bus.phase_i      = '0;
    bus.phase_load_i = 1'b0;
    bus.clr_i        = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (obs_vec() !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", obs_vec(), 19'd0);
    end
    $display("reset: obs=%h", obs_vec());
    rstn_i = 1'b1;
    model_reset();
  endtask

  task automatic test_fwd_fast();
    do_reset();
    bus.freq_i   = 32'h4000_0000;
    bus.enable_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL fwd_fast[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
      $display("fwd_fast %0d: iq=%b%b quad=%0d cnt=%0d slip=%b", k, bus.i_o, bus.q_o,
               bus.quadrant_o, bus.count_o, bus.slip_o);
    end
    // After 10 edges the output has stepped 9 times: Q=1, {i,q}=10
    checks++;
    if ({bus.i_o, bus.q_o, bus.count_o} !== {2'b10, 14'd9}) begin
      errors++;
      $display("FAIL fwd_fast_end: got %b%b/%0d required 10/9", bus.i_o, bus.q_o, bus.count_o);
    end
  endtask

  task automatic test_fwd_slow();
    do_reset();
    bus.freq_i   = 32'h1000_0000;
    bus.enable_i = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL fwd_slow[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
      $display("fwd_slow %0d: iq=%b%b cnt=%0d", k, bus.i_o, bus.q_o, bus.count_o);
      if (k == 17) begin
        checks++;
        if (bus.count_o !== 14'sd4) begin
          errors++;
          $display("FAIL fwd_slow_count: got %0d required 4", bus.count_o);
        end
      end
    end
  endtask

  task automatic test_reverse();
    do_reset();
    bus.freq_i   = 32'hF000_0000;
    bus.enable_i = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL reverse[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
      $display("reverse %0d: iq=%b%b cnt=%0d", k, bus.i_o, bus.q_o, bus.count_o);
    end
    // First reverse step lands at edge 2 (Q=3, {i,q}=01); then one per 4 edges
    checks++;
    if ({bus.slip_o, bus.count_o} !== {1'b0, -14'sd8}) begin
      errors++;
      $display("FAIL reverse_end: got slip=%b cnt=%0d required slip=0 cnt=-8", bus.slip_o, bus.count_o);
    end
  endtask

  task automatic test_slip_clr();
    do_reset();
    bus.freq_i   = 32'h6000_0000;
    bus.enable_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL slip[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
      $display("slip %0d: quad=%0d cnt=%0d slip=%b", k, bus.quadrant_o, bus.count_o, bus.slip_o);
    end
    checks++;
    if (bus.slip_o !== 1'b1) begin
      errors++;
      $display("FAIL slip_set: got %b required 1", bus.slip_o);
    end
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    checks++;
    if ({bus.slip_o, bus.count_o} !== 15'd0 || obs_vec() !== model_vec()) begin
      errors++;
      $display("FAIL slip_clear: got %h required %h", obs_vec(), model_vec());
    end
    $display("slip clear: cnt=%0d slip=%b", bus.count_o, bus.slip_o);
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    do_reset();
    bus.freq_i   = 32'h4000_0000;
    bus.enable_i = 1'b1;
    for (int k = 1; k <= 9000; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL saturation[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
    end
    checks++;
    if (bus.count_o !== 14'sd8191) begin
      errors++;
      $display("FAIL saturation_max: got %0d required 8191", bus.count_o);
    end
    $display("saturation: cnt=%0d iq=%b%b", bus.count_o, bus.i_o, bus.q_o);
  endtask

  task automatic test_phase_load();
    do_reset();
    bus.phase_i      = 32'h4000_0000;
    bus.phase_load_i = 1'b1;
    cycle();
    bus.phase_load_i = 1'b0;
    cycle();
    checks++;
    if ({bus.quadrant_o, bus.i_o, bus.q_o} !== 4'b01_10 || obs_vec() !== model_vec()) begin
      errors++;
      $display("FAIL phase_load: got %h required %h", obs_vec(), model_vec());
    end
    $display("phase_load: quad=%0d iq=%b%b", bus.quadrant_o, bus.i_o, bus.q_o);
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bus.enable_i = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       bus.freq_i = $urandom;
        1:       bus.freq_i = $urandom_range(0, 32'h3FFF_FFFF);
        2:       bus.freq_i = 32'd0 - $urandom_range(0, 32'h3FFF_FFFF);
        default: ;
      endcase
      bus.phase_i      = $urandom;
      bus.phase_load_i = ($urandom_range(0, 19) == 0);
      bus.clr_i        = ($urandom_range(0, 29) == 0);
      cycle();
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h required %h", k, obs_vec(), model_vec());
      end
    end
    drive_idle();
    $display("random: 600 cycles, last cnt=%0d", bus.count_o);
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.freq_i   = 32'h4000_0000;
    bus.enable_i = 1'b1;
    repeat (7) cycle();
    #2;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", obs_vec(), 19'd0);
    end
    model_reset();
    cycle();
    checks++;
    if (obs_vec() !== 19'd0) begin
      errors++;
      $display("FAIL async_reset_hold: got %h required %h", obs_vec(), 19'd0);
    end
    rstn_i = 1'b1;
    repeat (3) cycle();
    checks++;
    if (obs_vec() !== model_vec()) begin
      errors++;
      $display("FAIL async_reset_resume: got %h required %h", obs_vec(), model_vec());
    end
    $display("async_reset: resumed quad=%0d cnt=%0d", bus.quadrant_o, bus.count_o);
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_fwd_fast();
    test_fwd_slow();
    test_reverse();
    test_slip_clr();
    test_phase_load();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
